// File: rtl/mux3_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mux3_rr_arbiter_pkg
// Shared definitions for the three-way round-robin arbiter slice:
//   - select/owner encodings (SEL_REQ0..SEL_REQ2, SEL_NONE)
//   - arbiter state enum (IDLE, LOCK)
//   - default data width
//   - small helpers to index a 3-bit request vector with a 2-bit select
// No ports (package).
// -----------------------------------------------------------------------------
package mux3_rr_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] SEL_REQ0 = 2'b00;
  localparam logic [1:0] SEL_REQ1 = 2'b01;
  localparam logic [1:0] SEL_REQ2 = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Selects one bit of a per-requester vector; SEL_NONE yields 0 so that
  // an idle owner never looks like a valid or last beat.
  function automatic logic pick_bit(input logic [2:0] v, input logic [1:0] idx);
    case (idx)
      SEL_REQ0: return v[0];
      SEL_REQ1: return v[1];
      SEL_REQ2: return v[2];
      default:  return 1'b0;
    endcase
  endfunction

  // One-hot mask for a select value; SEL_NONE gives an empty mask.
  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    case (idx)
      SEL_REQ0: return 3'b001;
      SEL_REQ1: return 3'b010;
      SEL_REQ2: return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/bit32_3to1mux.sv
// -----------------------------------------------------------------------------
// bit32_3to1mux
// Three-to-one word multiplexer. Outputs zero when no input is selected.
// Ports:
//   sel  in  2      00=d0, 01=d1, 10=d2, 11=zero
//   d0   in  WIDTH  input word 0
//   d1   in  WIDTH  input word 1
//   d2   in  WIDTH  input word 2
//   y    out WIDTH  selected word
// -----------------------------------------------------------------------------
module bit32_3to1mux #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] y
);

  // Plain word select; the unused code forces the output to zero.
  always_comb begin
    case (sel)
      2'b00:   y = d0;
      2'b01:   y = d1;
      2'b10:   y = d2;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mux3_rr_arbiter_rr_pick3.sv
// -----------------------------------------------------------------------------
// rr_pick3
// Round-robin pick among three requesters. The search starts at the
// requester after ptr and wraps 2 -> 0, so the last winner has lowest priority.
// Ports:
//   req     in  3  request vector, bit i = requester i
//   ptr     in  2  last winner (SEL_NONE is treated like requester 2)
//   winner  out 2  chosen requester, SEL_NONE when nothing requests
//   any     out 1  at least one request present
// -----------------------------------------------------------------------------
module rr_pick3
  import mux3_rr_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       any
);

  // Priority order rotates with the pointer: ptr=0 -> 1,2,0; ptr=1 -> 2,0,1;
  // ptr=2 -> 0,1,2.
  always_comb begin
    winner = SEL_NONE;
    any    = |req;
    case (ptr)
      SEL_REQ0: begin
        if      (req[1]) winner = SEL_REQ1;
        else if (req[2]) winner = SEL_REQ2;
        else if (req[0]) winner = SEL_REQ0;
      end
      SEL_REQ1: begin
        if      (req[2]) winner = SEL_REQ2;
        else if (req[0]) winner = SEL_REQ0;
        else if (req[1]) winner = SEL_REQ1;
      end
      default: begin
        if      (req[0]) winner = SEL_REQ0;
        else if (req[1]) winner = SEL_REQ1;
        else if (req[2]) winner = SEL_REQ2;
      end
    endcase
  end

endmodule

// File: rtl/mux3_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux3_rr_arbiter
// Shares one registered valid/ready output channel between three producers
// with packet-level round-robin grant locking. A grant is taken in IDLE and
// held in LOCK until the owner's last beat transfers.
// Ports:
//   clk            in  1      clock, rising edge
//   rst_n          in  1      asynchronous active-low reset
//   req_valid      in  3      per-requester beat valid
//   req_last       in  3      per-requester end-of-packet, qualified by valid
//   req_data0..2   in  WIDTH  requester words
//   req_ready      out 3      per-requester beat accept (owner only)
//   sel            out 2      mux select, 11 = none
//   out_valid      out 1      output word valid
//   out_data       out WIDTH  registered output word
//   out_last       out 1      registered end-of-packet flag
//   out_ready      in  1      downstream accept
//   owner          out 2      current grant owner, 11 = none
//   timeout_pulse  out 1      (MUX3_ARB_TIMEOUT_EN only) forced release strobe
// Optional feature macro: MUX3_ARB_TIMEOUT_EN releases a grant after TIMEOUT
// consecutive LOCK cycles without owner valid.
// -----------------------------------------------------------------------------
module mux3_rr_arbiter
  import mux3_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
`ifdef MUX3_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       req_valid,
  input  logic [2:0]       req_last,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [WIDTH-1:0] req_data2,
  output logic [2:0]       req_ready,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [1:0]       owner
`ifdef MUX3_ARB_TIMEOUT_EN
  , output logic           timeout_pulse
`endif
);

  arb_state_t       state_q, state_d;
  logic [1:0]       sel_d, owner_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       pick_winner;
  logic             pick_any;
  logic [WIDTH-1:0] mux_data;
  logic             own_valid, own_last, slot_free, xfer, force_release;

  rr_pick3 u_pick (
    .req    (req_valid),
    .ptr    (ptr_q),
    .winner (pick_winner),
    .any    (pick_any)
  );

  bit32_3to1mux #(.WIDTH(WIDTH)) u_mux (
    .sel (sel),
    .d0  (req_data0),
    .d1  (req_data1),
    .d2  (req_data2),
    .y   (mux_data)
  );

  assign own_valid = pick_bit(req_valid, owner);
  assign own_last  = pick_bit(req_last, owner);
  // The output register can take a word if it is empty or draining this cycle.
  assign slot_free = !out_valid || out_ready;

`ifdef MUX3_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] stall_cnt;

  // The TIMEOUT-th consecutive stalled LOCK cycle triggers the release.
  assign force_release = (state_q == LOCK) && !own_valid &&
                         (stall_cnt == CNT_W'(TIMEOUT - 1));
  assign timeout_pulse = force_release;

  // Stall counter: counts LOCK cycles without owner valid, cleared by any
  // owner transfer, by leaving LOCK, and by the forced release itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state_q != LOCK || xfer || force_release) begin
      stall_cnt <= '0;
    end else if (!own_valid) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign force_release = 1'b0;
`endif

  // Next-state logic: IDLE arbitrates and takes a grant, LOCK serves the
  // owner until its last beat (or a forced release) and then hands the
  // pointer to the owner so it drops to lowest priority.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel;
    owner_d   = owner;
    ptr_d     = ptr_q;
    req_ready = 3'b000;
    xfer      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_d   = pick_winner;
          owner_d = pick_winner;
          state_d = LOCK;
        end
      end
      LOCK: begin
        req_ready = onehot3(owner) & {3{slot_free}};
        xfer      = own_valid && slot_free;
        if ((xfer && own_last) || force_release) begin
          ptr_d   = owner;
          sel_d   = SEL_NONE;
          owner_d = SEL_NONE;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = SEL_NONE;
        owner_d = SEL_NONE;
      end
    endcase
  end

  // State register for the grant FSM, select, owner and round-robin pointer.
  // The pointer resets to 2 so requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel     <= SEL_NONE;
      owner   <= SEL_NONE;
      ptr_q   <= SEL_REQ2;
    end else begin
      state_q <= state_d;
      sel     <= sel_d;
      owner   <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Output stage: loads on a transfer, otherwise empties when the consumer
  // takes the word. Data and last are only written on a load so they stay
  // stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_last  <= own_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux3_rr_arbiter
// Directed bench for mux3_rr_arbiter. Stimulus tasks load per-requester beat
// queues and push the expected output words into a scoreboard queue; an
// independent monitor pops and compares whenever the output word drains.
// Honors MUX3_ARB_TIMEOUT_EN to match the DUT build.
// -----------------------------------------------------------------------------
module tb_mux3_rr_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       req_valid;
  logic [2:0]       req_last;
  logic [WIDTH-1:0] req_data0, req_data1, req_data2;
  logic [2:0]       req_ready;
  logic [1:0]       sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_ready;
  logic [1:0]       owner;
`ifdef MUX3_ARB_TIMEOUT_EN
  logic             timeout_pulse;
`endif

  int errors = 0;
  int checks = 0;

  // Beat entries are {last, data}.
  logic [WIDTH:0] expQ[$];
  logic [WIDTH:0] q0[$], q1[$], q2[$];
  logic [2:0]     mask = 3'b000;
  logic [2:0]     fire = 3'b000;
  logic           outReadyNext = 1'b1;
  int             cycleCount = 0;
  int             pulseCount = 0;
  bit             recordPops = 1'b0;
  int             popCycles[$];
  bit             holdPrev = 1'b0;
  logic [WIDTH:0] holdWord;

  mux3_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_data2 (req_data2),
    .req_ready (req_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .owner     (owner)
`ifdef MUX3_ARB_TIMEOUT_EN
    , .timeout_pulse (timeout_pulse)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One bench cycle: retire beats accepted at the previous edge, drive the
  // heads of the beat queues, then record which beats will fire next edge.
  task automatic applyStimulus();
    @(negedge clk);
    if (fire[0]) void'(q0.pop_front());
    if (fire[1]) void'(q1.pop_front());
    if (fire[2]) void'(q2.pop_front());
    req_valid[0] = (q0.size() > 0) && !mask[0];
    req_data0    = (q0.size() > 0) ? q0[0][WIDTH-1:0] : '0;
    req_last[0]  = (q0.size() > 0) ? q0[0][WIDTH] : 1'b0;
    req_valid[1] = (q1.size() > 0) && !mask[1];
    req_data1    = (q1.size() > 0) ? q1[0][WIDTH-1:0] : '0;
    req_last[1]  = (q1.size() > 0) ? q1[0][WIDTH] : 1'b0;
    req_valid[2] = (q2.size() > 0) && !mask[2];
    req_data2    = (q2.size() > 0) ? q2[0][WIDTH-1:0] : '0;
    req_last[2]  = (q2.size() > 0) ? q2[0][WIDTH] : 1'b0;
    out_ready    = outReadyNext;
    #1;
    fire = rst_n ? (req_valid & req_ready) : 3'b000;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while ((expQ.size() > 0 || q0.size() > 0 || q1.size() > 0 || q2.size() > 0)
           && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput({name, "_drain"}, 64'(expQ.size()), 64'd0);
    applyStimulus();
    applyStimulus();
  endtask

  // Scoreboard monitor: a word drains whenever out_valid and out_ready are
  // both high at the upcoming edge; it also checks hold behavior on stalls.
  always begin
    @(negedge clk);
    #2;
`ifdef MUX3_ARB_TIMEOUT_EN
    if (timeout_pulse === 1'b1) pulseCount++;
`endif
    if (holdPrev && rst_n) begin
      checkOutput("hold_valid", 64'(out_valid), 64'd1);
      checkOutput("hold_data", 64'({out_last, out_data}), 64'(holdWord));
    end
    holdPrev = 1'b0;
    if (out_valid === 1'b1 && out_ready === 1'b0) begin
      checkOutput("stall_ready", 64'(req_ready), 64'd0);
      holdPrev = 1'b1;
      holdWord = {out_last, out_data};
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_word", 64'({out_last, out_data}), 64'h1_DEAD_BEEF);
      end else begin
        checkOutput("out_word", 64'({out_last, out_data}), 64'(expQ.pop_front()));
        if (recordPops) popCycles.push_back(cycleCount);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 3'b000;
    req_last  = 3'b000;
    req_data0 = '0;
    req_data1 = '0;
    req_data2 = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_sel", 64'(sel), 64'h3);
    checkOutput("rst_owner", 64'(owner), 64'h3);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_out_last", 64'(out_last), 64'd0);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;

    // Test 1: all three valid with 1-beat packets; requester 0 has a second.
    $display("[TB] test 1: round robin 1-beat packets");
    q0 = '{{1'b1, 32'hA0}, {1'b1, 32'hA3}};
    q1 = '{{1'b1, 32'hB1}};
    q2 = '{{1'b1, 32'hC2}};
    expQ = '{{1'b1, 32'hA0}, {1'b1, 32'hB1}, {1'b1, 32'hC2}, {1'b1, 32'hA3}};
    recordPops = 1'b1;
    waitDrain("t1", 40);
    recordPops = 1'b0;
    checkOutput("t1_pop_count", 64'(popCycles.size()), 64'd4);
    for (int i = 1; i < popCycles.size(); i++)
      checkOutput("t1_spacing", 64'(popCycles[i] - popCycles[i-1]), 64'd2);

    // Test 2: requester 1 4-beat packet while requester 0 waits (ptr=0).
    $display("[TB] test 2: packet lock");
    q1 = '{{1'b0, 32'h10}, {1'b0, 32'h11}, {1'b0, 32'h12}, {1'b1, 32'h13}};
    q0 = '{{1'b1, 32'h05}};
    expQ = '{{1'b0, 32'h10}, {1'b0, 32'h11}, {1'b0, 32'h12}, {1'b1, 32'h13},
             {1'b1, 32'h05}};
    begin
      int n = 0;
      while (q1.size() > 0 && n < 30) begin
        applyStimulus();
        if (q1.size() > 0 && !(q1.size() == 1 && fire[1]) && owner == 2'b01)
          checkOutput("t2_req0_blocked", 64'(req_ready[0]), 64'd0);
        n++;
      end
    end
    waitDrain("t2", 30);

    // Test 3: requester 2 packet with out_ready low for 3 cycles mid-packet.
    $display("[TB] test 3: downstream stall");
    q2 = '{{1'b0, 32'h20}, {1'b0, 32'h21}, {1'b0, 32'h22}, {1'b1, 32'h23}};
    expQ = '{{1'b0, 32'h20}, {1'b0, 32'h21}, {1'b0, 32'h22}, {1'b1, 32'h23}};
    begin
      int n = 0;
      while (!(q2.size() == 3 && fire[2]) && n < 20) begin
        applyStimulus();
        n++;
      end
      checkOutput("t3_reach_stall", 64'(n < 20), 64'd1);
    end
    applyStimulus();
    outReadyNext = 1'b0;
    repeat (3) begin
      applyStimulus();
      checkOutput("t3_owner_ready", 64'(req_ready), 64'd0);
    end
    outReadyNext = 1'b1;
    waitDrain("t3", 30);

    // Test 4: reset during beat 2 of a 3-beat packet from requester 0.
    $display("[TB] test 4: reset mid-packet");
    q0 = '{{1'b0, 32'h30}, {1'b0, 32'h31}, {1'b1, 32'h32}};
    expQ = '{{1'b0, 32'h30}};
    begin
      int n = 0;
      while (!(q0.size() == 2 && fire[0]) && n < 20) begin
        applyStimulus();
        n++;
      end
      checkOutput("t4_reach_beat2", 64'(n < 20), 64'd1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t4_out_valid", 64'(out_valid), 64'd0);
    checkOutput("t4_sel", 64'(sel), 64'h3);
    checkOutput("t4_owner", 64'(owner), 64'h3);
    q0.delete();
    fire = 3'b000;
    req_valid = 3'b000;
    @(negedge clk);
    checkOutput("t4_scoreboard", 64'(expQ.size()), 64'd0);
    rst_n = 1'b1;
    q1 = '{{1'b1, 32'h41}};
    q0 = '{{1'b1, 32'h40}};
    expQ = '{{1'b1, 32'h40}, {1'b1, 32'h41}};
    waitDrain("t4", 30);

    // Test 5: no requests for 10 cycles.
    $display("[TB] test 5: idle");
    repeat (10) begin
      applyStimulus();
      checkOutput("t5_sel", 64'(sel), 64'h3);
      checkOutput("t5_out_valid", 64'(out_valid), 64'd0);
    end

    // Test 6: owner stalls mid-packet (ptr=1 so requester 0 wins).
    $display("[TB] test 6: owner stall");
    q0 = '{{1'b0, 32'h60}, {1'b1, 32'h62}};
    q1 = '{{1'b1, 32'h61}};
`ifdef MUX3_ARB_TIMEOUT_EN
    expQ = '{{1'b0, 32'h60}, {1'b1, 32'h61}, {1'b1, 32'h62}};
`else
    expQ = '{{1'b0, 32'h60}, {1'b1, 32'h62}, {1'b1, 32'h61}};
`endif
    begin
      int n = 0;
      while (!fire[0] && n < 20) begin
        applyStimulus();
        n++;
      end
      checkOutput("t6_first_beat", 64'(n < 20), 64'd1);
    end
    mask[0] = 1'b1;
    pulseCount = 0;
    repeat (100) applyStimulus();
`ifdef MUX3_ARB_TIMEOUT_EN
    checkOutput("t6_pulse_count", 64'(pulseCount), 64'd1);
    checkOutput("t6_req1_served", 64'(q1.size()), 64'd0);
`else
    checkOutput("t6_owner_held", 64'(owner), 64'h0);
    checkOutput("t6_sel_held", 64'(sel), 64'h0);
    checkOutput("t6_req1_blocked", 64'(req_ready[1]), 64'd0);
`endif
    mask[0] = 1'b0;
    waitDrain("t6", 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
